buzzer_round_ctrl: RTL and testbench
====================================

Name: buzzer_round_ctrl

Overview:
- Quiz-buzzer round controller for the party box: debounces the four player KEY buttons and sequences a buzz-in round.
- Locks the first valid press, resolves same-cycle ties round-robin, and measures reaction time.
- The Nios arms and clears rounds through PIO pulses, then reads winner, foul and timing status for HEX/LEDR/VGA display.

Parameters:
- NUM_PLAYERS, 4, number of player buttons (2..4); ID width is 2 bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- TIMER_W, 32, reaction counter width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- KEY  in  NUM_PLAYERS  raw buttons, active-low, asynchronous.
- arm  in  1  single-cycle pulse from Nios: start a round.
- clear  in  1  single-cycle pulse from Nios: end the round, clear fouls.
- armed  out  1  high in ARMED.
- winner_valid  out  1  high in LOCKED.
- winner_id  out  2  index of the locked player.
- winner_onehot  out  NUM_PLAYERS  one-hot of winner_id, qualified by winner_valid; drives LEDR.
- foul_mask  out  NUM_PLAYERS  players who pressed before arm.
- reaction_cycles  out  TIMER_W  cycles from arm to lock.
- pressed  out  NUM_PLAYERS  debounced button levels, 1 = pressed.

Behaviour:
- Reset values:
  - State is IDLE.
  - armed, winner_valid, winner_id, winner_onehot, foul_mask, reaction_cycles and pressed are all 0.
  - Round-robin pointer is 0.
  - Debounce counters are 0.
- Input conditioning (per key):
  - Invert KEY, then pass it through a 2-flop synchronizer.
  - pressed[i] toggles only after the synchronized value has differed from pressed[i] for DEBOUNCE_CYCLES consecutive cycles.
  - The counter resets whenever the values agree.
  - press_edge[i] = pressed[i] rising.
  - Only edges count: a key already held at arm never wins.
- States:
  - IDLE:
    - A press_edge sets the corresponding foul_mask bit (sticky).
    - arm -> ARMED, reaction counter loads 0.
  - ARMED:
    - The reaction counter increments each cycle and saturates at all-ones.
    - Eligible edges = press_edge & ~foul_mask.
    - If any are eligible -> LOCKED on the next edge.
    - On lock, latch winner_id, latch reaction_cycles = counter value, and set the pointer to winner_id+1 mod NUM_PLAYERS.
    - arm while ARMED is ignored (no restart).
  - LOCKED:
    - All presses are ignored; foul_mask is not updated.
    - arm is ignored.
    - Outputs hold until clear.
  - clear in any state -> IDLE; winner_valid=0, winner_onehot=0, foul_mask=0.
    - winner_id and reaction_cycles keep their last values so the Nios can still read them.
- Tie-break:
  - Multiple eligible edges in one cycle pick the first index at or after the pointer, wrapping.
  - After reset the pointer is 0, so lowest index wins.
- Priorities:
  - clear beats arm in the same cycle; the result is IDLE.
  - clear beats a lock in the same cycle.
  - arm in the same cycle as an IDLE press_edge: the press is a foul (foul_mask is set) and the state becomes ARMED.
- Latency:
  - Stable KEY low is first sampled at edge 0.
  - pressed rises at edge DEBOUNCE_CYCLES+2.
  - winner_valid rises at edge DEBOUNCE_CYCLES+3.
  - reaction_cycles = number of ARMED cycles before the lock edge.
- Fouled players stay fouled through ARMED and LOCKED until clear.
- If all players are fouled, ARMED persists until clear.
- Reset mid-round returns to reset values immediately; no partial state survives.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=4): KEY[2] bounces low/high every 2 cycles for 20 cycles, then held low.
  - pressed stays 0 during bouncing.
  - pressed[2]=1 exactly 6 cycles after the stable low begins.
  - No lock while IDLE; foul_mask=4'b0100.
- Basic round: reset, arm, wait 10 cycles, press KEY[1] cleanly.
  - winner_valid=1, winner_id=1, winner_onehot=4'b0010.
  - reaction_cycles=10+7.
  - A later KEY[3] press changes nothing.
  - clear -> armed=0, winner_valid=0, winner_id still 1.
- Tie round-robin: after reset, arm, press KEY[1] and KEY[3] on the same cycle -> winner 1. Then clear, arm, and press both again on the same cycle -> winner 3 (pointer=2).
- Foul exclusion: press KEY[0] in IDLE (foul_mask=0001), release, arm, press KEY[0] then KEY[2] two cycles later -> winner_id=2. Then clear -> foul_mask=0.
- Held key and priorities:
  - Hold KEY[3] before arm -> no lock in ARMED.
  - Release and re-press KEY[3] -> it is still fouled, no lock.
  - arm and clear in the same cycle -> IDLE.
  - Assert reset while LOCKED -> all outputs 0 on the next cycle.
- Saturation (TIMER_W=4): arm, no press for 20 cycles, then press -> reaction_cycles=4'hF.

Source files
------------

// File: rtl/buzzer_round_ctrl.sv
// Quiz-buzzer round controller. Debounces the player KEY buttons, locks the
// first eligible press of an armed round, breaks same-cycle ties round-robin
// and records the reaction time from arm to lock.
//
// Ports:
//   CLOCK_50        system clock
//   reset           synchronous, active-high reset
//   KEY             raw player buttons, active-low, asynchronous
//   arm             one-cycle pulse: start a round
//   clear           one-cycle pulse: end the round and clear fouls
//   armed           high while a round is armed
//   winner_valid    high while a winner is locked
//   winner_id       index of the locked player (kept after clear)
//   winner_onehot   one-hot winner, qualified by winner_valid
//   foul_mask       players who pressed before arm
//   reaction_cycles cycles from arm to lock, saturating (kept after clear)
//   pressed         debounced button levels, 1 = pressed
module buzzer_round_ctrl #(
  parameter int unsigned NUM_PLAYERS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMER_W         = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] KEY,
  input  logic                   arm,
  input  logic                   clear,
  output logic                   armed,
  output logic                   winner_valid,
  output logic [1:0]             winner_id,
  output logic [NUM_PLAYERS-1:0] winner_onehot,
  output logic [NUM_PLAYERS-1:0] foul_mask,
  output logic [TIMER_W-1:0]     reaction_cycles,
  output logic [NUM_PLAYERS-1:0] pressed
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned IDX_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [NUM_PLAYERS-1:0] sync1_q, sync2_q;
  logic [NUM_PLAYERS-1:0] pressed_q, pressed_d;
  logic [NUM_PLAYERS-1:0] pressed_prev_q;
  logic [CNT_W-1:0]       db_cnt_q [NUM_PLAYERS];
  logic [CNT_W-1:0]       db_cnt_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] press_edge;

  // Debounce: a level change is accepted once the synchronized value has
  // disagreed with pressed for DEBOUNCE_CYCLES+1 consecutive samples.
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != pressed_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          pressed_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      pressed_q      <= '0;
      pressed_prev_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q        <= ~KEY;
      sync2_q        <= sync1_q;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
      for (int i = 0; i < NUM_PLAYERS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign press_edge = pressed_q & ~pressed_prev_q;

  // ---------------------------------------------------------------------
  // Round sequencing
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [TIMER_W-1:0]     timer_q, timer_d, timer_inc;
  logic [ID_W-1:0]        winner_id_q, winner_id_d;
  logic [NUM_PLAYERS-1:0] onehot_q, onehot_d;
  logic [NUM_PLAYERS-1:0] foul_q, foul_d;
  logic [TIMER_W-1:0]     rc_q, rc_d;
  logic                   armed_q, armed_d;
  logic                   valid_q, valid_d;

  logic [NUM_PLAYERS-1:0] eligible;
  logic                   found;
  logic [ID_W-1:0]        pick;
  logic                   lock;

  assign eligible  = press_edge & ~foul_q;
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
  assign lock      = (state_q == S_ARMED) && found && !clear;

  // Round-robin pick: first eligible index at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
      if (!found && eligible[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // State register plus the registered round outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      winner_id_q <= '0;
      onehot_q    <= '0;
      foul_q      <= '0;
      rc_q        <= '0;
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      winner_id_q <= winner_id_d;
      onehot_q    <= onehot_d;
      foul_q      <= foul_d;
      rc_q        <= rc_d;
      armed_q     <= armed_d;
      valid_q     <= valid_d;
    end
  end

  // Next state; clear overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (arm) state_d = S_ARMED;
      S_ARMED:  if (found) state_d = S_LOCKED;
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Round datapath and output register inputs.
  always_comb begin
    int unsigned nxt;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    winner_id_d = winner_id_q;
    onehot_d    = onehot_q;
    foul_d      = foul_q;
    rc_d        = rc_q;
    nxt         = int'(pick) + 1;
    if (nxt >= NUM_PLAYERS) nxt = 0;

    case (state_q)
      S_IDLE: begin
        // A press landing with arm is still a foul.
        foul_d = foul_q | press_edge;
        if (arm) timer_d = '0;
      end
      S_ARMED: begin
        timer_d = timer_inc;
        if (lock) begin
          winner_id_d = pick;
          onehot_d    = NUM_PLAYERS'(1) << pick;
          rc_d        = timer_inc;
          ptr_d       = ID_W'(nxt);
        end
      end
      default: ;
    endcase

    if (clear) begin
      foul_d   = '0;
      onehot_d = '0;
    end

    armed_d = (state_d == S_ARMED);
    valid_d = (state_d == S_LOCKED);
  end

  assign armed           = armed_q;
  assign winner_valid    = valid_q;
  assign winner_id       = winner_id_q;
  assign winner_onehot   = onehot_q;
  assign foul_mask       = foul_q;
  assign reaction_cycles = rc_q;
  assign pressed         = pressed_q;

endmodule

// File: tb/tb_buzzer_round_ctrl.sv
// Bench for buzzer_round_ctrl with a short debounce window. A second instance
// with a 4-bit reaction timer shares the stimulus to check saturation.
module tb_buzzer_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       arm;
  logic       clr;

  logic        armed, wv;
  logic [1:0]  wid;
  logic [3:0]  woh, foul, pr;
  logic [31:0] rc;

  logic        s_armed, s_wv;
  logic [1:0]  s_wid;
  logic [3:0]  s_woh, s_foul, s_pr;
  logic [3:0]  s_rc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  buzzer_round_ctrl #(.NUM_PLAYERS(4), .DEBOUNCE_CYCLES(4), .TIMER_W(32)) dut (
    .CLOCK_50(clk), .reset(rst), .KEY(key), .arm(arm), .clear(clr),
    .armed(armed), .winner_valid(wv), .winner_id(wid), .winner_onehot(woh),
    .foul_mask(foul), .reaction_cycles(rc), .pressed(pr)
  );

  buzzer_round_ctrl #(.NUM_PLAYERS(4), .DEBOUNCE_CYCLES(4), .TIMER_W(4)) dut_sat (
    .CLOCK_50(clk), .reset(rst), .KEY(key), .arm(arm), .clear(clr),
    .armed(s_armed), .winner_valid(s_wv), .winner_id(s_wid), .winner_onehot(s_woh),
    .foul_mask(s_foul), .reaction_cycles(s_rc), .pressed(s_pr)
  );

  typedef struct {
    logic        r;
    logic [3:0]  k;
    logic        a;
    logic        c;
    int          cyc;
    logic        e_armed;
    logic        e_wv;
    logic [1:0]  e_id;
    logic [3:0]  e_oh;
    logic [3:0]  e_foul;
    logic [3:0]  e_pr;
    logic [31:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] k, input logic a,
                              input logic c, input int cyc, input logic e_armed,
                              input logic e_wv, input logic [1:0] e_id,
                              input logic [3:0] e_oh, input logic [3:0] e_foul,
                              input logic [3:0] e_pr, input logic [31:0] e_rc);
    vec_t v;
    v.r = r; v.k = k; v.a = a; v.c = c; v.cyc = cyc;
    v.e_armed = e_armed; v.e_wv = e_wv; v.e_id = e_id; v.e_oh = e_oh;
    v.e_foul = e_foul; v.e_pr = e_pr; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for n cycles (pulses only on the first), ending at a negedge.
  task automatic drive(input logic r, input logic [3:0] k, input logic a,
                       input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      rst = (i == 0) ? r : 1'b0;
      arm = (i == 0) ? a : 1'b0;
      clr = (i == 0) ? c : 1'b0;
      key = k;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    arm = 1'b0;
    clr = 1'b0;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".armed"},  32'(armed), 32'(v.e_armed));
    chk({tag, ".valid"},  32'(wv),    32'(v.e_wv));
    chk({tag, ".id"},     32'(wid),   32'(v.e_id));
    chk({tag, ".onehot"}, 32'(woh),   32'(v.e_oh));
    chk({tag, ".foul"},   32'(foul),  32'(v.e_foul));
    chk({tag, ".pressed"},32'(pr),    32'(v.e_pr));
    chk({tag, ".rc"},     rc,         v.e_rc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; key = 4'hF; arm = 1'b0; clr = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'hF, 1'b0, 1'b0, 2);
    chk_all("reset", mk(0, 4'hF, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));

    // Bouncing KEY[2]: never accepted.
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 2; j++) begin
        drive(1'b0, 4'hB, 1'b0, 1'b0, 1);
        chk($sformatf("bounce_lo%0d", b), 32'(pr), 32'h0);
      end
      for (int j = 0; j < 2; j++) begin
        drive(1'b0, 4'hF, 1'b0, 1'b0, 1);
        chk($sformatf("bounce_hi%0d", b), 32'(pr), 32'h0);
      end
    end
    // Stable low first sampled at edge 0; pressed rises at edge 6 (7th edge).
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 4'hB, 1'b0, 1'b0, 1);
      chk($sformatf("settle%0d", k), 32'(pr), (k >= 7) ? 32'h4 : 32'h0);
    end
    drive(1'b0, 4'hB, 1'b0, 1'b0, 3);
    chk("idle_press.valid", 32'(wv), 32'h0);
    chk("idle_press.armed", 32'(armed), 32'h0);
    chk("idle_press.foul", 32'(foul), 32'h4);
    drive(1'b0, 4'hF, 1'b0, 1'b0, 8);

    // r, key, arm, clr, cycles | armed, valid, id, onehot, foul, pressed, rc
    // Basic round: arm, 10 cycles, KEY[1] -> lock 7 edges later, rc = 17.
    vecs.push_back(mk(1, 4'hF, 0, 0, 1,  0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 10, 1, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'hD, 0, 0, 7,  1, 0, 2'd0, 4'h0, 4'h0, 4'h2, 0));
    vecs.push_back(mk(0, 4'hD, 0, 0, 1,  0, 1, 2'd1, 4'h2, 4'h0, 4'h2, 17));
    vecs.push_back(mk(0, 4'h5, 0, 0, 10, 0, 1, 2'd1, 4'h2, 4'h0, 4'hA, 17));
    vecs.push_back(mk(0, 4'hF, 0, 1, 1,  0, 0, 2'd1, 4'h0, 4'h0, 4'hA, 17));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8,  0, 0, 2'd1, 4'h0, 4'h0, 4'h0, 17));
    // Ties: pointer 0 -> player 1, then pointer 2 -> player 3.
    vecs.push_back(mk(1, 4'hF, 0, 0, 1,  0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 1,  1, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'h5, 0, 0, 7,  1, 0, 2'd0, 4'h0, 4'h0, 4'hA, 0));
    vecs.push_back(mk(0, 4'h5, 0, 0, 1,  0, 1, 2'd1, 4'h2, 4'h0, 4'hA, 8));
    vecs.push_back(mk(0, 4'hF, 0, 1, 8,  0, 0, 2'd1, 4'h0, 4'h0, 4'h0, 8));
    vecs.push_back(mk(0, 4'hF, 1, 0, 1,  1, 0, 2'd1, 4'h0, 4'h0, 4'h0, 8));
    vecs.push_back(mk(0, 4'h5, 0, 0, 7,  1, 0, 2'd1, 4'h0, 4'h0, 4'hA, 8));
    vecs.push_back(mk(0, 4'h5, 0, 0, 1,  0, 1, 2'd3, 4'h8, 4'h0, 4'hA, 8));
    vecs.push_back(mk(0, 4'hF, 0, 1, 8,  0, 0, 2'd3, 4'h0, 4'h0, 4'h0, 8));
    // Foul exclusion: KEY[0] fouled in IDLE, KEY[2] wins 10 cycles after arm.
    vecs.push_back(mk(0, 4'hE, 0, 0, 8,  0, 0, 2'd3, 4'h0, 4'h1, 4'h1, 8));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8,  0, 0, 2'd3, 4'h0, 4'h1, 4'h0, 8));
    vecs.push_back(mk(0, 4'hF, 1, 0, 1,  1, 0, 2'd3, 4'h0, 4'h1, 4'h0, 8));
    vecs.push_back(mk(0, 4'hE, 0, 0, 2,  1, 0, 2'd3, 4'h0, 4'h1, 4'h0, 8));
    vecs.push_back(mk(0, 4'hA, 0, 0, 6,  1, 0, 2'd3, 4'h0, 4'h1, 4'h1, 8));
    vecs.push_back(mk(0, 4'hA, 0, 0, 1,  1, 0, 2'd3, 4'h0, 4'h1, 4'h5, 8));
    vecs.push_back(mk(0, 4'hA, 0, 0, 1,  0, 1, 2'd2, 4'h4, 4'h1, 4'h5, 10));
    vecs.push_back(mk(0, 4'hF, 0, 1, 1,  0, 0, 2'd2, 4'h0, 4'h0, 4'h5, 10));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8,  0, 0, 2'd2, 4'h0, 4'h0, 4'h0, 10));
    // Held key stays fouled; arm+clear lands in IDLE.
    vecs.push_back(mk(0, 4'h7, 0, 0, 8,  0, 0, 2'd2, 4'h0, 4'h8, 4'h8, 10));
    vecs.push_back(mk(0, 4'h7, 1, 0, 1,  1, 0, 2'd2, 4'h0, 4'h8, 4'h8, 10));
    vecs.push_back(mk(0, 4'h7, 0, 0, 10, 1, 0, 2'd2, 4'h0, 4'h8, 4'h8, 10));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8,  1, 0, 2'd2, 4'h0, 4'h8, 4'h0, 10));
    vecs.push_back(mk(0, 4'h7, 0, 0, 8,  1, 0, 2'd2, 4'h0, 4'h8, 4'h8, 10));
    vecs.push_back(mk(0, 4'hF, 1, 1, 1,  0, 0, 2'd2, 4'h0, 4'h0, 4'h8, 10));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8,  0, 0, 2'd2, 4'h0, 4'h0, 4'h0, 10));
    // Reset while LOCKED.
    vecs.push_back(mk(0, 4'hF, 1, 0, 1,  1, 0, 2'd2, 4'h0, 4'h0, 4'h0, 10));
    vecs.push_back(mk(0, 4'hE, 0, 0, 8,  0, 1, 2'd0, 4'h1, 4'h0, 4'h1, 8));
    vecs.push_back(mk(1, 4'hF, 0, 0, 1,  0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 4,  0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0));

    for (int s = 0; s < vecs.size(); s++) begin
      drive(vecs[s].r, vecs[s].k, vecs[s].a, vecs[s].c, vecs[s].cyc);
      chk_all($sformatf("step%0d", s), vecs[s]);
    end

    // Clear beats a lock in the same cycle: arm at edge A, KEY[1] first
    // sampled at A+1, lock would be at A+8 -- clear lands exactly there.
    drive(1'b0, 4'hF, 1'b1, 1'b0, 1);
    drive(1'b0, 4'hD, 1'b0, 1'b0, 7);
    drive(1'b0, 4'hD, 1'b0, 1'b1, 1);
    chk("clr_lock.valid", 32'(wv), 32'h0);
    chk("clr_lock.armed", 32'(armed), 32'h0);
    chk("clr_lock.onehot", 32'(woh), 32'h0);
    drive(1'b0, 4'hF, 1'b0, 1'b0, 8);

    // Saturation: arm, 20 idle cycles, KEY[1]; lock 27 cycles after arm.
    drive(1'b1, 4'hF, 1'b0, 1'b0, 1);
    drive(1'b0, 4'hF, 1'b1, 1'b0, 20);
    drive(1'b0, 4'hD, 1'b0, 1'b0, 8);
    chk("sat.rc32", rc, 32'd27);
    chk("sat.rc4", 32'(s_rc), 32'hF);
    chk("sat.valid4", 32'(s_wv), 32'h1);
    chk("sat.id4", 32'(s_wid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
